data_mem_responder: RTL and testbench

Memory-side responder for the CPU data/instruction port. It accepts one request at a time over a valid/ready handshake and serves it from an internal word-organised array. Accesses take a programmable number of wait states. Byte and halfword stores are done as read-modify-write; byte and halfword loads are zero-extended. Requests that are misaligned, out of range or use a reserved size are rejected with an error response and never touch the array.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/data_mem_responder_if.sv | 31 +++
 rtl/byte_lane_merge.sv | 61 ++++++
 rtl/data_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared size/state encodings and alignment helper for data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    // Matches the CPU MemDataSize encoding
    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        MERGE  = 3'd3,
        RESP   = 3'd4
    } resp_state_t;

    // Only the two low address bits decide alignment
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input mem_size_t size);
        logic r;
        case (size)
            SZ_HALF: r = addr_lo[0];
            SZ_WORD: r = (addr_lo != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module   : data_mem_responder_if
// Brief    : Request/response handshake bundle between CPU port and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/byte_lane_merge.sv
// ============================================================================
// Module   : byte_lane_merge
// Brief    : Little-endian lane insert (stores) and zero-extended extract (loads).
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  mem_size_t   i_size,
    output logic [31:0] o_merged,
    output logic [31:0] o_extract
);

    always_comb begin
        o_merged  = i_old_word;
        o_extract = i_old_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'd0: begin
                        o_merged[7:0]   = i_wdata[7:0];
                        o_extract       = {24'd0, i_old_word[7:0]};
                    end
                    2'd1: begin
                        o_merged[15:8]  = i_wdata[7:0];
                        o_extract       = {24'd0, i_old_word[15:8]};
                    end
                    2'd2: begin
                        o_merged[23:16] = i_wdata[7:0];
                        o_extract       = {24'd0, i_old_word[23:16]};
                    end
                    default: begin
                        o_merged[31:24] = i_wdata[7:0];
                        o_extract       = {24'd0, i_old_word[31:24]};
                    end
                endcase
            end
            SZ_HALF: begin
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                    o_extract       = {16'd0, i_old_word[31:16]};
                end else begin
                    o_merged[15:0]  = i_wdata[15:0];
                    o_extract       = {16'd0, i_old_word[15:0]};
                end
            end
            default: begin
                o_merged  = i_wdata;
                o_extract = i_old_word;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Single-outstanding memory responder with wait states and RMW stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                 Clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        (WAIT_STATES > 0) ? c_CNT_W'(WAIT_STATES - 1) : '0;

    resp_state_t          r_state;
    resp_state_t          w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;

    logic [c_IDX_W-1:0]   r_idx;
    logic [1:0]           r_lane;
    logic                 r_wr;
    mem_size_t            r_size;
    logic [31:0]          r_wdata;
    logic                 r_err;
    logic [31:0]          r_old;
    logic [31:0]          r_rdata;
    logic                 r_rsp_err;

    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_accept;
    mem_size_t            w_req_size;
    logic                 w_req_err;
    logic                 w_subword;
    logic [31:0]          w_word;
    logic [31:0]          w_lane_old;
    logic [31:0]          w_merged;
    logic [31:0]          w_extract;
    logic                 w_mem_we;

    assign w_accept   = bus.req_valid && (r_state == IDLE);
    assign w_req_size = mem_size_t'(bus.req_size);
    assign w_req_err  = (w_req_size == SZ_RSVD)
                     || is_misaligned(bus.req_addr[1:0], w_req_size)
                     || ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign w_subword  = (r_size != SZ_WORD);
    assign w_word     = r_mem[r_idx];
    assign w_lane_old = (r_state == MERGE) ? r_old : w_word;

    byte_lane_merge u_lane (
        .i_old_word (w_lane_old),
        .i_wdata    (r_wdata),
        .i_addr_lo  (r_lane),
        .i_size     (r_size),
        .o_merged   (w_merged),
        .o_extract  (w_extract)
    );

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_rsp_err;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Errors bypass WAIT and pass through ACCESS without touching the array,
    // so their response lands one cycle after accept.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err || (WAIT_STATES == 0)) begin
                        w_next_state = ACCESS;
                    end else begin
                        w_next_state = WAIT;
                        w_cnt_next   = '0;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_next_state = ACCESS;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ACCESS: begin
                if (!r_err && r_wr && w_subword) begin
                    w_next_state = MERGE;
                end else begin
                    w_next_state = RESP;
                end
            end
            MERGE: w_next_state = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_idx     <= '0;
            r_lane    <= 2'b00;
            r_wr      <= 1'b0;
            r_size    <= SZ_WORD;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_old     <= '0;
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx   <= bus.req_addr[c_IDX_W+1:2];
                        r_lane  <= bus.req_addr[1:0];
                        r_wr    <= bus.req_wr;
                        r_size  <= w_req_size;
                        r_wdata <= bus.req_wdata;
                        r_err   <= w_req_err;
                    end
                end
                ACCESS: begin
                    if (r_err) begin
                        r_rsp_err <= 1'b1;
                    end else if (!r_wr) begin
                        r_rdata <= w_extract;
                    end else if (w_subword) begin
                        r_old <= w_word;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rdata   <= '0;
                        r_rsp_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word stores write in ACCESS; sub-word stores write the merged word in MERGE
    assign w_mem_we = ((r_state == ACCESS) && !r_err && r_wr && !w_subword)
                   || (r_state == MERGE);

    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= w_merged;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench; dut_a uses 1 wait state, dut_b uses 3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic Clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    data_mem_responder_if ifa();
    data_mem_responder_if ifb();

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) dut_a (
        .Clk(Clk), .reset(reset), .bus(ifa.slave)
    );
    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut_b (
        .Clk(Clk), .reset(reset), .bus(ifb.slave)
    );

    always #5 Clk = ~Clk;

    task automatic drive_req(input bit b, input bit v, input bit wr, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd);
        if (b) begin
            ifb.req_valid = v; ifb.req_wr = wr; ifb.req_size = sz;
            ifb.req_addr = addr; ifb.req_wdata = wd;
        end else begin
            ifa.req_valid = v; ifa.req_wr = wr; ifa.req_size = sz;
            ifa.req_addr = addr; ifa.req_wdata = wd;
        end
    endtask

    task automatic set_rsp_ready(input bit b, input bit r);
        if (b) ifb.rsp_ready = r; else ifa.rsp_ready = r;
    endtask

    task automatic get_out(input bit b, output logic rv, output logic rq,
                           output logic [31:0] rd, output logic er);
        if (b) begin
            rv = ifb.rsp_valid; rq = ifb.req_ready; rd = ifb.rsp_rdata; er = ifb.rsp_err;
        end else begin
            rv = ifa.rsp_valid; rq = ifa.req_ready; rd = ifa.rsp_rdata; er = ifa.rsp_err;
        end
    endtask

    // Runs one full transaction; lat counts edges from accept to first rsp_valid
    task automatic issue(input bit b, input bit wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        logic rv, rq;
        bit   got;
        @(negedge Clk);
        drive_req(b, 1'b1, wr, sz, addr, wd);
        @(posedge Clk); #1;
        drive_req(b, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        lat = 0;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            get_out(b, rv, rq, rd, er);
            if (rv === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge Clk); #1;
            lat++;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL issue_timeout addr=%h: rsp_valid never seen, required within 30 cycles", addr);
            lat = -1;
        end
        set_rsp_ready(b, 1'b1);
        @(posedge Clk); #1;
        set_rsp_ready(b, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        set_rsp_ready(1'b0, 1'b0);
        set_rsp_ready(1'b1, 1'b0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_chk++; if (ifa.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", ifa.req_ready); else n_pass++;
        n_chk++; if (ifa.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", ifa.rsp_valid); else n_pass++;
        n_chk++; if (ifa.rsp_rdata !== 32'd0) $display("FAIL reset_rsp_rdata got %h exp 0", ifa.rsp_rdata); else n_pass++;
        n_chk++; if (ifa.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b exp 0", ifa.rsp_err); else n_pass++;
        reset = 1'b1;
        @(posedge Clk); #1;
        n_chk++; if (ifb.req_ready !== 1'b1) $display("FAIL reset_b_req_ready got %b exp 1", ifb.req_ready); else n_pass++;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er;
        issue(1'b0, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        n_chk++; if (lat != 2) $display("FAIL word_store_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (er !== 1'b0 || rd !== 32'd0) $display("FAIL word_store_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); else n_pass++;
        issue(1'b0, 1'b0, 2'd0, 32'h10, 32'd0, lat, rd, er);
        n_chk++; if (lat != 2) $display("FAIL word_load_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (rd !== 32'hDEADBEEF) $display("FAIL word_load_rdata got %h exp deadbeef", rd); else n_pass++;
        n_chk++; if (er !== 1'b0) $display("FAIL word_load_err got %b exp 0", er); else n_pass++;
    endtask

    task automatic test_byte_rmw();
        int lat; logic [31:0] rd; logic er;
        issue(1'b0, 1'b1, 2'd0, 32'h20, 32'h11223344, lat, rd, er);
        issue(1'b0, 1'b1, 2'd1, 32'h22, 32'h000000AA, lat, rd, er);
        n_chk++; if (lat != 3) $display("FAIL byte_store_latency got %0d exp 3", lat); else n_pass++;
        n_chk++; if (er !== 1'b0) $display("FAIL byte_store_err got %b exp 0", er); else n_pass++;
        issue(1'b0, 1'b0, 2'd0, 32'h20, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'h11AA3344) $display("FAIL byte_rmw_word got %h exp 11aa3344", rd); else n_pass++;
        issue(1'b0, 1'b0, 2'd1, 32'h23, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'h00000011) $display("FAIL byte_load_lane3 got %h exp 00000011", rd); else n_pass++;
        n_chk++; if (lat != 2) $display("FAIL byte_load_latency got %0d exp 2", lat); else n_pass++;
        issue(1'b0, 1'b0, 2'd1, 32'h21, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'h00000033) $display("FAIL byte_load_lane1 got %h exp 00000033", rd); else n_pass++;
        issue(1'b0, 1'b0, 2'd2, 32'h20, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'h00003344) $display("FAIL half_load_low got %h exp 00003344", rd); else n_pass++;
    endtask

    task automatic test_halfword();
        int lat; logic [31:0] rd; logic er;
        issue(1'b0, 1'b1, 2'd0, 32'h24, 32'h12345678, lat, rd, er);
        issue(1'b0, 1'b1, 2'd2, 32'h26, 32'h0000BEEF, lat, rd, er);
        n_chk++; if (lat != 3) $display("FAIL half_store_latency got %0d exp 3", lat); else n_pass++;
        issue(1'b0, 1'b0, 2'd2, 32'h26, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'h0000BEEF) $display("FAIL half_load_high got %h exp 0000beef", rd); else n_pass++;
        issue(1'b0, 1'b1, 2'd2, 32'h25, 32'h00001111, lat, rd, er);
        n_chk++; if (er !== 1'b1) $display("FAIL half_misaligned_err got %b exp 1", er); else n_pass++;
        n_chk++; if (rd !== 32'd0) $display("FAIL half_misaligned_rdata got %h exp 0", rd); else n_pass++;
        n_chk++; if (lat != 1) $display("FAIL half_misaligned_latency got %0d exp 1", lat); else n_pass++;
        issue(1'b0, 1'b0, 2'd0, 32'h24, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'hBEEF5678) $display("FAIL half_word_unchanged got %h exp beef5678", rd); else n_pass++;
    endtask

    task automatic test_range_size();
        int lat; logic [31:0] rd; logic er;
        issue(1'b0, 1'b1, 2'd0, 32'h0, 32'h01020304, lat, rd, er);
        issue(1'b0, 1'b0, 2'd0, 32'h100, 32'd0, lat, rd, er);
        n_chk++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL range_load got err=%b rdata=%h exp err=1 rdata=0", er, rd); else n_pass++;
        n_chk++; if (lat != 1) $display("FAIL range_load_latency got %0d exp 1", lat); else n_pass++;
        issue(1'b0, 1'b1, 2'd0, 32'h100, 32'hFFFFFFFF, lat, rd, er);
        n_chk++; if (er !== 1'b1) $display("FAIL range_store_err got %b exp 1", er); else n_pass++;
        issue(1'b0, 1'b1, 2'd3, 32'h0, 32'hFFFFFFFF, lat, rd, er);
        n_chk++; if (er !== 1'b1) $display("FAIL rsvd_size_err got %b exp 1", er); else n_pass++;
        issue(1'b0, 1'b1, 2'd0, 32'h2, 32'hFFFFFFFF, lat, rd, er);
        n_chk++; if (er !== 1'b1) $display("FAIL word_misaligned_err got %b exp 1", er); else n_pass++;
        issue(1'b0, 1'b0, 2'd0, 32'h0, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'h01020304 || er !== 1'b0) $display("FAIL error_no_change got err=%b rdata=%h exp err=0 rdata=01020304", er, rd); else n_pass++;
        issue(1'b0, 1'b1, 2'd0, 32'hFC, 32'hA5A5A5A5, lat, rd, er);
        issue(1'b0, 1'b0, 2'd0, 32'hFC, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) $display("FAIL last_word got err=%b rdata=%h exp err=0 rdata=a5a5a5a5", er, rd); else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er; logic rv, rq;
        bit got;
        @(negedge Clk);
        drive_req(1'b0, 1'b1, 1'b0, 2'd0, 32'h10, 32'd0);
        @(posedge Clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ifa.rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge Clk); #1;
        end
        n_chk++; if (!got) $display("FAIL bp_rsp_timeout got rsp_valid=%b exp 1 within 30 cycles", ifa.rsp_valid); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            get_out(1'b0, rv, rq, rd, er);
            n_chk++;
            if (rv !== 1'b1 || rq !== 1'b0 || rd !== 32'hDEADBEEF || er !== 1'b0)
                $display("FAIL bp_hold_%0d got valid=%b ready=%b rdata=%h err=%b exp valid=1 ready=0 rdata=deadbeef err=0",
                         c, rv, rq, rd, er);
            else n_pass++;
            @(negedge Clk);
            if (c == 1) drive_req(1'b0, 1'b1, 1'b1, 2'd0, 32'h10, 32'h0);
            else        drive_req(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
            @(posedge Clk); #1;
        end
        set_rsp_ready(1'b0, 1'b1);
        @(posedge Clk); #1;
        set_rsp_ready(1'b0, 1'b0);
        get_out(1'b0, rv, rq, rd, er);
        n_chk++;
        if (rq !== 1'b1 || rv !== 1'b0 || rd !== 32'd0 || er !== 1'b0)
            $display("FAIL bp_release got ready=%b valid=%b rdata=%h err=%b exp ready=1 valid=0 rdata=0 err=0", rq, rv, rd, er);
        else n_pass++;
        issue(1'b0, 1'b0, 2'd0, 32'h10, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'hDEADBEEF) $display("FAIL bp_pulse_ignored got %h exp deadbeef", rd); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int lat; logic [31:0] rd; logic er; logic rv, rq;
        issue(1'b1, 1'b1, 2'd0, 32'h30, 32'h0, lat, rd, er);
        n_chk++; if (lat != 4) $display("FAIL w3_store_latency got %0d exp 4", lat); else n_pass++;
        @(negedge Clk);
        drive_req(1'b1, 1'b1, 1'b1, 2'd0, 32'h30, 32'hCAFEF00D);
        @(posedge Clk); #1;
        drive_req(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        @(posedge Clk); #1;
        n_chk++; if (ifb.req_ready !== 1'b0) $display("FAIL w3_busy_in_wait got req_ready=%b exp 0", ifb.req_ready); else n_pass++;
        #2 reset = 1'b0;
        #1;
        get_out(1'b1, rv, rq, rd, er);
        n_chk++;
        if (rq !== 1'b1 || rv !== 1'b0 || rd !== 32'd0 || er !== 1'b0)
            $display("FAIL async_reset_outputs got ready=%b valid=%b rdata=%h err=%b exp ready=1 valid=0 rdata=0 err=0", rq, rv, rd, er);
        else n_pass++;
        @(posedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        issue(1'b1, 1'b0, 2'd0, 32'h30, 32'd0, lat, rd, er);
        n_chk++; if (rd !== 32'h00000000) $display("FAIL reset_abort_store got %h exp 00000000", rd); else n_pass++;
        n_chk++; if (lat != 4) $display("FAIL w3_load_latency got %0d exp 4", lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_halfword();
        test_range_size();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

`default_nettype wire
